sprite_blit_ctrl: RTL
=====================

Name: sprite_blit_ctrl

Overview:
- Sequences one draw operation into the vga_adapter framebuffer (160x120, 3-bit colour).
- A sprite draw copies a 1-bit SPR_W x SPR_H picture from the pic ROM to screen position (x0,y0), with a foreground colour, a background colour, optional transparency and screen-edge clipping.
- A clear draw fills the whole screen with bg_colour and does not read the ROM.
- Sits between game logic (start/done handshake) and the vga_adapter x/y/colour/plot inputs.

Parameters:
- SPR_W, 32, sprite width in pixels
- SPR_H, 32, sprite height in pixels
- ROM_AW, 10, ROM address width; must satisfy 2**ROM_AW >= SPR_W*SPR_H
- SCR_W, 160, screen width
- SCR_H, 120, screen height

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- start  in  1  request a draw; sampled only in IDLE
- clear_mode  in  1  1 = full-screen clear, 0 = sprite draw; latched with start
- transparent  in  1  1 = ROM 0-pixels are not plotted; latched with start
- x0  in  8  sprite left column; latched with start
- y0  in  7  sprite top row; latched with start
- fg_colour  in  3  colour for ROM 1-pixels; latched with start
- bg_colour  in  3  colour for ROM 0-pixels and for clear; latched with start
- rom_addr  out  ROM_AW  pic ROM address
- rom_q  in  1  ROM data; registered ROM, valid one cycle after rom_addr
- vga_x  out  8  framebuffer column
- vga_y  out  7  framebuffer row
- vga_colour  out  3  pixel colour
- vga_plot  out  1  write strobe
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (on the clock edge where reset=1): state goes to IDLE. The following all go to 0: vga_plot, busy, done, rom_addr, vga_x, vga_y, vga_colour and every counter. Reset mid-operation abandons the draw. No plot occurs on the cycle after reset, and no done pulse is produced.
- States: IDLE -> SCAN -> FLUSH -> DONE -> IDLE.
- IDLE: when start=1, latch all request inputs and go to SCAN. The cycle in which start is sampled is cycle 0.
- SCAN:
  - Scan counters are i (column, 0..W-1) and j (row, 0..H-1), stepped raster-order, one pixel per cycle.
  - Sprite draw: W=SPR_W, H=SPR_H.
  - Clear draw: W=SCR_W, H=SCR_H, and the x0/y0 offset is forced to 0.
  - rom_addr is a linear counter equal to j*SPR_W+i. It is driven only in sprite mode and held at 0 in clear mode.
  - After the pixel (W-1,H-1), go to FLUSH.
- Pipeline:
  - Address for pixel k is issued in cycle 1+k; rom_q for it is valid in cycle 2+k.
  - vga_* outputs are registered. The outputs for pixel k appear in cycle 3+k.
  - Pixel coordinates are delayed alongside the ROM so that x, y and colour always match.
- FLUSH: drains the two-stage pipeline, lasting 2 cycles, then goes to DONE.
- DONE: done=1 for exactly one cycle with busy=0, then return to IDLE.
- Timing with N=W*H:
  - busy is 1 in cycles 1..N+2.
  - The last possible plot is in cycle N+2.
  - done is 1 in cycle N+3.
- Coordinate arithmetic:
  - sx = x0+i and sy = y0+j are computed 9 bits wide (no wrap).
  - vga_x = sx[7:0], vga_y = sy[6:0].
- Plot rule:
  - vga_plot=1 only if sx<SCR_W and sy<SCR_H, and not (transparent=1 and rom_q=0).
  - Clipped or transparent pixels still consume their cycle, so timing is independent of content.
- Colour: rom_q=1 -> fg_colour; rom_q=0 -> bg_colour; clear mode -> bg_colour.
- When vga_plot=0, vga_x, vga_y and vga_colour hold their last values.
- start is ignored when not in IDLE, including in the DONE cycle. Request inputs changing mid-draw have no effect.

Decomposition:
- Package rps_gfx_pkg holds:
  - constants SCR_W=160, SCR_H=120
  - colour constants BLACK=3'b000, WHITE=3'b111
  - the state encoding IDLE/SCAN/FLUSH/DONE
- One sub-module, blit_scan_counter. It is a raster i/j counter with width/height inputs, an enable input, and last-pixel and linear-address outputs.
- Pipeline, clip logic and FSM live in sprite_blit_ctrl.

Test Plan:
- Clear: reset, then start with clear_mode=1, bg=3'b000 -> exactly 19200 plots covering x 0..159 and y 0..119 in raster order with colour 0; done in cycle 19203; busy=0 in that cycle.
- Sprite at (10,20), SPR 32x32, checkerboard ROM, fg=7, bg=0, transparent=0 -> 1024 plots with x 10..41 and y 20..51; colour matches the ROM bit at each pixel; first plot in cycle 3; done in cycle 1027.
- Transparency: same sprite with transparent=1 -> exactly 512 plots, all colour 7, at the checkerboard 1-positions only; done still in cycle 1027.
- Clipping: start at (150,110) -> plots only for x 150..159 and y 110..119 (100 plots); no plot with vga_x>=160 or vga_y>=120; done in cycle 1027.
- Reset mid-draw: assert reset in cycle 500 of a sprite draw -> vga_plot=0, busy=0, done=0 from the next cycle; a new start then draws normally from pixel 0.
- Ignored start: pulse start in cycle 200 and in the DONE cycle with x0=0 -> still exactly one draw at the original (10,20) and a single done pulse; IDLE afterwards.

Source files
------------

// File: rtl/rps_gfx_pkg.sv
// Shared graphics definitions for the rock-paper-scissors display path.
// Holds the framebuffer dimensions, the two fixed colours and the
// state encoding of the draw sequencer.
package rps_gfx_pkg;

  localparam int SCR_W = 160;
  localparam int SCR_H = 120;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/blit_scan_counter.sv
// Raster-order column/row counter for the blitter.
// Ports:
//   i_clock, i_reset : clock and synchronous active-high reset
//   i_en             : advance one pixel this cycle
//   i_width/i_height : extent of the area being scanned (both >= 1)
//   o_col/o_row      : current pixel position
//   o_addr           : linear pixel index, row*width+col
//   o_last           : current pixel is the final one of the area
module blit_scan_counter #(
  parameter int AW = 10
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_en,
  input  logic [7:0]    i_width,
  input  logic [6:0]    i_height,
  output logic [7:0]    o_col,
  output logic [6:0]    o_row,
  output logic [AW-1:0] o_addr,
  output logic          o_last
);

  logic [7:0]    r_col;
  logic [6:0]    r_row;
  logic [AW-1:0] r_addr;
  logic          w_row_end;

  assign w_row_end = (r_col == i_width - 8'd1);
  assign o_last    = w_row_end && (r_row == i_height - 7'd1);
  assign o_col     = r_col;
  assign o_row     = r_row;
  assign o_addr    = r_addr;

  // The linear address is a plain incrementer: stepping in raster order
  // keeps it equal to row*width+col without a multiplier.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
    end else if (i_en) begin
      if (o_last) begin
        r_col  <= '0;
        r_row  <= '0;
        r_addr <= '0;
      end else if (w_row_end) begin
        r_col  <= '0;
        r_row  <= r_row + 7'd1;
        r_addr <= r_addr + AW'(1);
      end else begin
        r_col  <= r_col + 8'd1;
        r_addr <= r_addr + AW'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_blit_ctrl.sv
// Draw sequencer between game logic and the vga_adapter framebuffer.
// Copies a 1-bit SPR_W x SPR_H picture from the pic ROM to (x0,y0) with
// fg/bg colours, optional transparency and screen-edge clipping, or fills
// the whole screen with bg_colour in clear mode.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   start, clear_mode, transparent, x0, y0, fg_colour, bg_colour
//                           : draw request, latched when start is seen in IDLE
//   rom_addr / rom_q        : pic ROM interface (registered ROM, 1-cycle latency)
//   vga_x, vga_y, vga_colour, vga_plot : framebuffer write port
//   busy, done              : operation in progress / one-cycle completion pulse
module sprite_blit_ctrl #(
  parameter int SPR_W  = 32,
  parameter int SPR_H  = 32,
  parameter int ROM_AW = 10,
  parameter int SCR_W  = rps_gfx_pkg::SCR_W,
  parameter int SCR_H  = rps_gfx_pkg::SCR_H
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              clear_mode,
  input  logic              transparent,
  input  logic [7:0]        x0,
  input  logic [6:0]        y0,
  input  logic [2:0]        fg_colour,
  input  logic [2:0]        bg_colour,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic              rom_q,
  output logic [7:0]        vga_x,
  output logic [6:0]        vga_y,
  output logic [2:0]        vga_colour,
  output logic              vga_plot,
  output logic              busy,
  output logic              done
);
  import rps_gfx_pkg::*;

  state_t r_state, w_next;
  logic   r_flush;

  logic       r_clear, r_transp;
  logic [7:0] r_x0;
  logic [6:0] r_y0;
  logic [2:0] r_fg, r_bg;

  logic [7:0]        w_width, w_col;
  logic [6:0]        w_height, w_row;
  logic [ROM_AW-1:0] w_addr;
  logic              w_last;

  logic       w_vld_p0;
  logic [8:0] w_sx_p0, w_sy_p0;
  logic       r_vld_p1;
  logic [8:0] r_sx_p1, r_sy_p1;

  logic [7:0] r_vga_x;
  logic [6:0] r_vga_y;
  logic [2:0] r_vga_colour;
  logic       r_plot;

  // Clear mode ignores transparency: a clear must cover every pixel.
  function automatic logic pixel_visible(input logic [8:0] sx, input logic [8:0] sy,
                                         input logic clear, input logic transp,
                                         input logic bit_q);
    return (sx < 9'(SCR_W)) && (sy < 9'(SCR_H)) && (clear || !transp || bit_q);
  endfunction

  function automatic logic [2:0] pick_colour(input logic clear, input logic bit_q,
                                             input logic [2:0] fg, input logic [2:0] bg);
    return (!clear && bit_q) ? fg : bg;
  endfunction

  // Request latch; clear mode forces the origin to the screen corner.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clear  <= 1'b0;
      r_transp <= 1'b0;
      r_x0     <= '0;
      r_y0     <= '0;
      r_fg     <= BLACK;
      r_bg     <= BLACK;
    end else if (r_state == IDLE && start) begin
      r_clear  <= clear_mode;
      r_transp <= transparent;
      r_x0     <= clear_mode ? 8'd0 : x0;
      r_y0     <= clear_mode ? 7'd0 : y0;
      r_fg     <= fg_colour;
      r_bg     <= bg_colour;
    end
  end

  assign w_width  = r_clear ? 8'(SCR_W) : 8'(SPR_W);
  assign w_height = r_clear ? 7'(SCR_H) : 7'(SPR_H);

  blit_scan_counter #(.AW(ROM_AW)) u_scan (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_en     (w_vld_p0),
    .i_width  (w_width),
    .i_height (w_height),
    .o_col    (w_col),
    .o_row    (w_row),
    .o_addr   (w_addr),
    .o_last   (w_last)
  );

  assign rom_addr = r_clear ? '0 : w_addr;

  // FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_next;
      r_flush <= (r_state == FLUSH) ? ~r_flush : 1'b0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SCAN;
      SCAN:    if (w_last) w_next = FLUSH;
      FLUSH:   if (r_flush) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign busy = (r_state == SCAN) || (r_state == FLUSH);
  assign done = (r_state == DONE);

  // p0: address issued, screen coordinates formed 9 bits wide
  assign w_vld_p0 = (r_state == SCAN);
  assign w_sx_p0  = {1'b0, r_x0} + {1'b0, w_col};
  assign w_sy_p0  = {2'b0, r_y0} + {2'b0, w_row};

  // p1: coordinates wait here while the ROM read completes
  always_ff @(posedge clock) begin
    if (reset) r_vld_p1 <= 1'b0;
    else       r_vld_p1 <= w_vld_p0;
  end

  always_ff @(posedge clock) begin
    r_sx_p1 <= w_sx_p0;
    r_sy_p1 <= w_sy_p0;
  end

  // p2: registered framebuffer write; position/colour hold when not plotting
  always_ff @(posedge clock) begin
    if (reset) begin
      r_plot       <= 1'b0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= BLACK;
    end else if (r_vld_p1 && pixel_visible(r_sx_p1, r_sy_p1, r_clear, r_transp, rom_q)) begin
      r_plot       <= 1'b1;
      r_vga_x      <= r_sx_p1[7:0];
      r_vga_y      <= r_sy_p1[6:0];
      r_vga_colour <= pick_colour(r_clear, rom_q, r_fg, r_bg);
    end else begin
      r_plot       <= 1'b0;
    end
  end

  assign vga_plot   = r_plot;
  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;

endmodule
